// File: rtl/hvmux_seq.sv
// HV mux pattern sequencer: hands each table entry to the mux SPI controller,
// lets the analog path settle, then triggers and waits for one acquisition.
module hvmux_seq #(
   parameter int unsigned SWITCH_N    = 16,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned SETTLE_CYC  = 64,
   parameter int unsigned ACQ_TIMEOUT = 65535
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_wr,
   input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
   input  logic [SWITCH_N-1:0]        cfg_data,
   input  logic [$clog2(DEPTH):0]     cfg_len,
   input  logic                       loop_en,
   input  logic                       start,
   input  logic                       abort,
   output logic [SWITCH_N-1:0]        mux_din,
   output logic                       mux_dvalid,
   input  logic                       mux_busy,
   output logic                       acq_trig,
   input  logic                       acq_done,
   output logic                       busy,
   output logic [$clog2(DEPTH)-1:0]   cur_idx,
   output logic                       done,
   output logic                       timeout_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned SW = (SETTLE_CYC  < 2) ? 1 : $clog2(SETTLE_CYC);
   localparam int unsigned TW = (ACQ_TIMEOUT < 2) ? 1 : $clog2(ACQ_TIMEOUT);

   typedef enum logic [3:0] {
      IDLE, SEND, ARM, WAIT_SPI, SETTLE, TRIG, WAIT_ACQ, NEXT,
      SAFE_HOLD, SAFE_SEND, SAFE_ARM, SAFE_WAIT
   } state_t;

   state_t              state;
   logic [SWITCH_N-1:0] tbl [DEPTH];
   logic [LW-1:0]       len_q;
   logic                loop_q;
   logic [SW-1:0]       settle_cnt;
   logic [TW-1:0]       tmo_cnt;
   logic                abortable;
   logic                last_entry;

   assign abortable  = state inside {SEND, ARM, WAIT_SPI, SETTLE, TRIG, WAIT_ACQ, NEXT};
   assign last_entry = ({1'b0, cur_idx} == (len_q - LW'(1)));

   // Pattern table: host-writable only while the sequencer is idle, never reset.
   always_ff @(posedge clk) begin
      if (cfg_wr && !busy) begin
         tbl[cfg_addr] <= cfg_data;
      end
   end

   // SAFE_HOLD waits out any SPI transfer still in flight before the all-open pattern is loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mux_din     <= '0;
         mux_dvalid  <= 1'b0;
         acq_trig    <= 1'b0;
         busy        <= 1'b0;
         cur_idx     <= '0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         len_q       <= '0;
         loop_q      <= 1'b0;
         settle_cnt  <= '0;
         tmo_cnt     <= '0;
      end else begin
         mux_dvalid <= 1'b0;
         acq_trig   <= 1'b0;
         done       <= 1'b0;
         if (abort && abortable) begin
            state <= SAFE_HOLD;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort && (cfg_len != '0)) begin
                     len_q       <= cfg_len;
                     loop_q      <= loop_en;
                     timeout_err <= 1'b0;
                     cur_idx     <= '0;
                     mux_din     <= tbl[AW'(0)];
                     mux_dvalid  <= 1'b1;
                     busy        <= 1'b1;
                     state       <= SEND;
                  end
               end
               SEND:     state <= ARM;
               ARM:      state <= WAIT_SPI;
               WAIT_SPI: begin
                  if (!mux_busy) begin
                     settle_cnt <= '0;
                     state      <= SETTLE;
                  end
               end
               SETTLE: begin
                  if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                     acq_trig <= 1'b1;
                     state    <= TRIG;
                  end else begin
                     settle_cnt <= settle_cnt + SW'(1);
                  end
               end
               TRIG: begin
                  tmo_cnt <= '0;
                  state   <= WAIT_ACQ;
               end
               WAIT_ACQ: begin
                  if (acq_done) begin
                     state <= NEXT;
                  end else if (tmo_cnt == TW'(ACQ_TIMEOUT - 1)) begin
                     timeout_err <= 1'b1;
                     state       <= SAFE_HOLD;
                  end else begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
               end
               NEXT: begin
                  if (!last_entry) begin
                     cur_idx    <= cur_idx + AW'(1);
                     mux_din    <= tbl[cur_idx + AW'(1)];
                     mux_dvalid <= 1'b1;
                     state      <= SEND;
                  end else if (loop_q) begin
                     cur_idx    <= '0;
                     mux_din    <= tbl[AW'(0)];
                     mux_dvalid <= 1'b1;
                     state      <= SEND;
                  end else begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
               SAFE_HOLD: begin
                  if (!mux_busy) begin
                     mux_din    <= '0;
                     mux_dvalid <= 1'b1;
                     state      <= SAFE_SEND;
                  end
               end
               SAFE_SEND: state <= SAFE_ARM;
               SAFE_ARM:  state <= SAFE_WAIT;
               SAFE_WAIT: begin
                  if (!mux_busy) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
               default:   state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hvmux_seq.sv
// Directed bench for hvmux_seq with a behavioural SPI mux controller and acquisition responder.
module tb_hvmux_seq;

   localparam int unsigned SWN = 16;
   localparam int unsigned DP  = 8;
   localparam int unsigned STL = 8;
   localparam int unsigned TMO = 100;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cfg_wr = 1'b0;
   logic [2:0]     cfg_addr = '0;
   logic [SWN-1:0] cfg_data = '0;
   logic [3:0]     cfg_len = '0;
   logic           loop_en = 1'b0;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic [SWN-1:0] mux_din;
   logic           mux_dvalid;
   logic           mux_busy = 1'b0;
   logic           acq_trig;
   logic           acq_done = 1'b0;
   logic           busy;
   logic [2:0]     cur_idx;
   logic           done;
   logic           timeout_err;

   hvmux_seq #(.SWITCH_N(SWN), .DEPTH(DP), .SETTLE_CYC(STL), .ACQ_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_len(cfg_len), .loop_en(loop_en), .start(start), .abort(abort),
      .mux_din(mux_din), .mux_dvalid(mux_dvalid), .mux_busy(mux_busy),
      .acq_trig(acq_trig), .acq_done(acq_done), .busy(busy), .cur_idx(cur_idx),
      .done(done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model state and logs, all owned by the negedge monitor below.
   int             cyc = 0, fall_cyc = -1000, trig_cyc = 0, err_cyc = 0;
   int             dv_n = 0, fall_n = 0, trig_n = 0, done_n = 0;
   int             viol = 0, tviol = 0, bdviol = 0;
   int             mb_cnt = 0, ac_cnt = 0;
   int             mbusy_len = 4;
   logic           acq_en = 1'b1;
   logic           prev_mb = 1'b0, prev_err = 1'b0;
   logic [SWN-1:0] din_log [64];
   logic [2:0]     idx_log [64];

   always @(negedge clk) begin
      cyc++;
      if (mux_dvalid) begin
         if (mux_busy) viol++;
         if (dv_n < 64) begin
            din_log[dv_n] = mux_din;
            idx_log[dv_n] = cur_idx;
         end
         dv_n++;
         mb_cnt = mbusy_len;
      end else if (mb_cnt > 0) begin
         mb_cnt--;
      end
      prev_mb  = mux_busy;
      mux_busy = (mb_cnt > 0);
      if (prev_mb && !mux_busy) begin
         fall_cyc = cyc;
         fall_n++;
      end
      acq_done = 1'b0;
      if (ac_cnt > 0) begin
         ac_cnt--;
         if (ac_cnt == 0) acq_done = 1'b1;
      end
      if (acq_trig) begin
         trig_n++;
         if (cyc - fall_cyc != int'(STL) + 1) tviol++;
         trig_cyc = cyc;
         if (acq_en) ac_cnt = 5;
      end
      if (done) begin
         done_n++;
         if (busy) bdviol++;
      end
      if (timeout_err && !prev_err) err_cyc = cyc;
      prev_err = timeout_err;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [SWN-1:0] d);
      cfg_addr = a;
      cfg_data = d;
      cfg_wr   = 1'b1;
      tick();
      cfg_wr   = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 3000) begin
         tick();
         n++;
      end
      if (busy) check({tag, "_idle_timeout"}, 32'(busy), 32'(0));
      tick();
      tick();
   endtask

   int b_dv, b_fall, b_trig, b_done, n;

   initial begin
      repeat (3) tick();
      check("rst_din", 32'(mux_din), 32'(0));
      check("rst_dvalid", 32'(mux_dvalid), 32'(0));
      check("rst_trig", 32'(acq_trig), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_idx", 32'(cur_idx), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_terr", 32'(timeout_err), 32'(0));
      rst = 1'b0;
      tick();

      // Three-entry one-shot run; cfg_len change after start must not matter.
      wr(3'd0, 16'h0001);
      wr(3'd1, 16'h0002);
      wr(3'd2, 16'h8000);
      b_dv = dv_n; b_trig = trig_n; b_done = done_n;
      cfg_len = 4'd3; loop_en = 1'b0;
      go();
      check("start_dvalid", 32'(mux_dvalid), 32'(1));
      check("start_idx", 32'(cur_idx), 32'(0));
      check("start_din", 32'(mux_din), 32'h0001);
      cfg_len = 4'd1;
      wait_idle("run3");
      check("run3_dv_count", 32'(dv_n - b_dv), 32'(3));
      check("run3_din0", 32'(din_log[b_dv]), 32'h0001);
      check("run3_din1", 32'(din_log[b_dv+1]), 32'h0002);
      check("run3_din2", 32'(din_log[b_dv+2]), 32'h8000);
      check("run3_idx1", 32'(idx_log[b_dv+1]), 32'(1));
      check("run3_idx2", 32'(idx_log[b_dv+2]), 32'(2));
      check("run3_trigs", 32'(trig_n - b_trig), 32'(3));
      check("run3_done", 32'(done_n - b_done), 32'(1));

      // Looping run aborted during SETTLE of the fifth entry.
      b_dv = dv_n; b_fall = fall_n; b_trig = trig_n; b_done = done_n;
      cfg_len = 4'd2; loop_en = 1'b1;
      go();
      loop_en = 1'b0;
      n = 0;
      while (fall_n < b_fall + 5 && n < 3000) begin tick(); n++; end
      check("loop_reach5", 32'(fall_n - b_fall), 32'(5));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_idle("loop_abort");
      check("loop_dv_count", 32'(dv_n - b_dv), 32'(6));
      check("loop_din2", 32'(din_log[b_dv+2]), 32'h0001);
      check("loop_din3", 32'(din_log[b_dv+3]), 32'h0002);
      check("loop_din4", 32'(din_log[b_dv+4]), 32'h0001);
      check("loop_idx3", 32'(idx_log[b_dv+3]), 32'(1));
      check("loop_safe_din", 32'(din_log[b_dv+5]), 32'(0));
      check("loop_trigs", 32'(trig_n - b_trig), 32'(4));
      check("loop_falls", 32'(fall_n - b_fall), 32'(6));
      check("loop_no_done", 32'(done_n - b_done), 32'(0));
      check("loop_idx_held", 32'(cur_idx), 32'(0));

      // Abort while the SPI transfer is still busy.
      b_dv = dv_n; b_trig = trig_n; b_done = done_n;
      mbusy_len = 20;
      cfg_len = 4'd1;
      go();
      tick();
      check("spi_busy_high", 32'(mux_busy), 32'(1));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_idle("spi_abort");
      mbusy_len = 4;
      check("spi_dv_count", 32'(dv_n - b_dv), 32'(2));
      check("spi_safe_din", 32'(din_log[b_dv+1]), 32'(0));
      check("spi_no_trig", 32'(trig_n - b_trig), 32'(0));
      check("spi_no_done", 32'(done_n - b_done), 32'(0));
      check("spi_din_hold", 32'(mux_din), 32'(0));

      // Acquisition timeout, then a clean restart clears the sticky flag.
      b_dv = dv_n; b_done = done_n;
      acq_en = 1'b0;
      go();
      wait_idle("tmo");
      check("tmo_flag", 32'(timeout_err), 32'(1));
      check("tmo_latency", 32'(err_cyc - trig_cyc), 32'(TMO + 1));
      check("tmo_safe_din", 32'(din_log[b_dv+1]), 32'(0));
      check("tmo_no_done", 32'(done_n - b_done), 32'(0));
      acq_en = 1'b1;
      go();
      check("tmo_clear", 32'(timeout_err), 32'(0));
      wait_idle("tmo_rerun");
      check("tmo_rerun_done", 32'(done_n - b_done), 32'(1));

      // Zero length start is ignored.
      b_dv = dv_n;
      cfg_len = 4'd0;
      go();
      tick();
      check("len0_busy", 32'(busy), 32'(0));
      check("len0_no_dv", 32'(dv_n - b_dv), 32'(0));

      // Table write during a run is dropped.
      cfg_len = 4'd3;
      go();
      tick();
      wr(3'd1, 16'hDEAD);
      wait_idle("wr_busy_run");
      b_dv = dv_n;
      go();
      wait_idle("wr_check_run");
      check("wr_ignored", 32'(din_log[b_dv+1]), 32'h0002);

      // Reset pulse while waiting for the acquisition.
      b_trig = trig_n;
      acq_en = 1'b0;
      go();
      n = 0;
      while (trig_n == b_trig && n < 500) begin tick(); n++; end
      check("rst_reach_acq", 32'(trig_n - b_trig), 32'(1));
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_din", 32'(mux_din), 32'(0));
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_idx", 32'(cur_idx), 32'(0));
      check("mid_rst_trig", 32'(acq_trig), 32'(0));
      check("mid_rst_terr", 32'(timeout_err), 32'(0));
      acq_en = 1'b1;
      b_dv = dv_n; b_done = done_n;
      go();
      check("post_rst_din", 32'(mux_din), 32'h0001);
      check("post_rst_idx", 32'(cur_idx), 32'(0));
      wait_idle("post_rst");
      check("post_rst_dv", 32'(dv_n - b_dv), 32'(3));
      check("post_rst_done", 32'(done_n - b_done), 32'(1));

      check("dvalid_while_busy", 32'(viol), 32'(0));
      check("trig_settle_timing", 32'(tviol), 32'(0));
      check("busy_at_done", 32'(bdviol), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
